// File: rtl/mem_access_ctrl.sv
// Load/store controller between execute and a word-addressed data memory.
// Checks alignment and range, does read-modify-write for sub-word stores.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          AW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [2:0]    req_op_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          resp_valid_o,
    output logic          resp_err_o,
    output logic [31:0]   resp_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [AW+1:0]   off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     word_q, word_d;
    logic            resp_err_q, resp_err_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;

    logic [31:0]     req_off;
    logic            is_half, is_word, misalign, out_of_range;

    function automatic logic [31:0] fmt_load(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   fmt_load = {{24{b[7]}}, b};
            OP_LBU:  fmt_load = {24'h0, b};
            OP_LH:   fmt_load = {{16{h[15]}}, h};
            OP_LHU:  fmt_load = {16'h0, h};
            default: fmt_load = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [31:0] d);
        merge = w;
        if (op == OP_SB) begin
            merge[{lane, 3'b000} +: 8] = d[7:0];
        end else if (op == OP_SH) begin
            if (lane[1]) merge[31:16] = d[15:0];
            else         merge[15:0]  = d[15:0];
        end else begin
            merge = d;
        end
    endfunction

    // Offset is modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign req_off      = req_addr_i - BASE_ADDR;
    assign is_half      = (req_op_i == OP_LHU) || (req_op_i == OP_LH) || (req_op_i == OP_SH);
    assign is_word      = (req_op_i == OP_LW) || (req_op_i == OP_SW);
    assign misalign     = (is_half && req_off[0]) || (is_word && (req_off[1:0] != 2'b00));
    assign out_of_range = |(req_off >> (AW + 2));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    off_d   = req_off[AW+1:0];
                    wdata_d = req_wdata_i;
                    if (misalign || out_of_range) begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end else if (req_op_i == OP_SW) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                word_d = mem_rdata_i;
                if (op_q == OP_SB || op_q == OP_SH) begin
                    state_d = S_WRITE;
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = fmt_load(op_q, off_q[1:0], mem_rdata_i);
                end
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LW;
            off_q        <= '0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Strobe decoded from state so an async reset in WRITE kills it immediately.
    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_we_o     = (state_q == S_WRITE);
    assign mem_addr_o   = off_q[AW+1:2];
    assign mem_wdata_o  = mem_we_o ? merge(op_q, off_q[1:0], word_q, wdata_q) : 32'h0;

endmodule
